// File: rtl/hamming_secded_decoder_if.sv
// Handshake bundle for the (16,11) SECDED decoder.
// The master drives codewords and consumes results; the slave is the decoder.
interface hamming_secded_decoder_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      code_in;
    logic             out_valid;
    logic             out_ready;
    logic [10:0]      data_out;
    logic             err_corr;
    logic             err_uncorr;
    logic [3:0]       syndrome_out;
    logic             cnt_clr;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    modport master (
        output in_valid, code_in, out_ready, cnt_clr,
        input  in_ready, out_valid, data_out, err_corr,
        input  err_uncorr, syndrome_out, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, code_in, out_ready, cnt_clr,
        output in_ready, out_valid, data_out, err_corr,
        output err_uncorr, syndrome_out, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamming_secded_decoder.sv
// Two-stage (16,11) SECDED decoder: S1 computes syndrome/parity, S2 fixes.
// Define HAMMING_ERR_CNT_EN to build the saturating error counters.
module hamming_secded_decoder #(
    parameter int CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    hamming_secded_decoder_if.slave bus
);

    function automatic logic [3:0] syn_of(input logic [15:0] c);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) begin
            if (c[4'(k)]) s ^= 4'(k);
        end
        return s;
    endfunction

    // Data lives at every position that is not a power of two (or zero).
    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int k = 0; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[4'(j)] = c[4'(k)];
                j++;
            end
        end
        return d;
    endfunction

    logic        s1_valid_q;
    logic [15:0] s1_code_q;
    logic [3:0]  s1_syn_q;
    logic        s1_par_q;

    logic        s2_valid_q;
    logic [10:0] data_q;
    logic        corr_q;
    logic        uncorr_q;
    logic [3:0]  syn_q;

    logic [15:0] fix_d;
    logic [10:0] data_d;
    logic        corr_d;
    logic        uncorr_d;

    logic s1_adv;
    logic s1_ld;
    logic xfer;

    assign s1_adv = !s2_valid_q || bus.out_ready;
    assign s1_ld  = !s1_valid_q || s1_adv;
    assign xfer   = s2_valid_q && bus.out_ready;

    always_comb begin
        fix_d    = '0;
        corr_d   = 1'b0;
        uncorr_d = 1'b0;
        unique case (1'b1)
            (s1_syn_q == 4'd0 && !s1_par_q): begin
                corr_d = 1'b0;
            end
            (s1_syn_q != 4'd0 && s1_par_q): begin
                fix_d  = 16'd1 << s1_syn_q;
                corr_d = 1'b1;
            end
            (s1_syn_q == 4'd0 && s1_par_q): begin
                corr_d = 1'b1;
            end
            default: begin
                uncorr_d = 1'b1;
            end
        endcase
        data_d = extract(s1_code_q ^ fix_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            corr_q     <= 1'b0;
            uncorr_q   <= 1'b0;
            syn_q      <= '0;
        end else begin
            if (s1_ld) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_code_q <= bus.code_in;
                    s1_syn_q  <= syn_of(bus.code_in);
                    s1_par_q  <= ^bus.code_in;
                end
            end
            if (s1_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    data_q   <= data_d;
                    corr_q   <= corr_d;
                    uncorr_q <= uncorr_d;
                    syn_q    <= s1_syn_q;
                end
            end
        end
    end

    assign bus.in_ready     = s1_ld;
    assign bus.out_valid    = s2_valid_q;
    assign bus.data_out     = data_q;
    assign bus.err_corr     = corr_q;
    assign bus.err_uncorr   = uncorr_q;
    assign bus.syndrome_out = syn_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] corr_cnt_q;
    logic [CNT_W-1:0] corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q;
    logic [CNT_W-1:0] uncorr_cnt_d;

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (bus.cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (xfer) begin
            if (corr_q && corr_cnt_q != '1)
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            if (uncorr_q && uncorr_cnt_q != '1)
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.corr_cnt   = corr_cnt_q;
    assign bus.uncorr_cnt = uncorr_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt     = bus.cnt_clr ^ xfer;
    assign bus.corr_cnt   = '0;
    assign bus.uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized bench for hamming_secded_decoder against an encode/inject model.
// Honours HAMMING_ERR_CNT_EN the same way as the design.
module tb_hamming_secded_decoder;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hamming_secded_decoder_if #(.CNT_W(CW)) bus ();

    hamming_secded_decoder #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] code;
        logic [10:0] data;
        logic [3:0]  syn;
        logic        c;
        logic        u;
        int          acc;
    } item_t;

    item_t q[$];
    item_t src[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    mc = 0;
    int    mu = 0;
    int    dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c = '0;
        for (int j = 0; j < 11; j++) c[4'(dpos[j])] = d[j];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 11; j++)
                if ((dpos[j] & (1 << i)) != 0) c[4'(1 << i)] ^= d[j];
        c[0] = ^c;
        return c;
    endfunction

    function automatic item_t mk(input logic [10:0] d, input int nerr);
        item_t it;
        int    p1, p2;
        it.code = encode(d);
        it.data = d;
        it.syn  = '0;
        it.c    = 1'b0;
        it.u    = 1'b0;
        it.acc  = 0;
        p1 = int'($urandom_range(15));
        p2 = (p1 + 1 + int'($urandom_range(14))) % 16;
        if (nerr == 1) begin
            it.code[4'(p1)] ^= 1'b1;
            it.syn = 4'(p1);
            it.c   = 1'b1;
        end else if (nerr == 2) begin
            it.code[4'(p1)] ^= 1'b1;
            it.code[4'(p2)] ^= 1'b1;
            it.syn = 4'(p1 ^ p2);
            it.u   = 1'b1;
            for (int j = 0; j < 11; j++)
                if (dpos[j] == p1 || dpos[j] == p2) it.data[j] ^= 1'b1;
        end
        return it;
    endfunction

    function automatic item_t fixed(input logic [15:0] code,
                                    input logic [10:0] data,
                                    input logic [3:0] syn,
                                    input logic c, input logic u);
        item_t it;
        it.code = code;
        it.data = data;
        it.syn  = syn;
        it.c    = c;
        it.u    = u;
        it.acc  = 0;
        return it;
    endfunction

    task automatic step();
        logic acc, xfer;
        #1;
        check("in_ready", bus.in_ready, bus.out_ready || q.size() < 2);
        check("out_valid", bus.out_valid,
              q.size() > 0 && (cyc - q[0].acc) >= 2);
        if (bus.out_valid && q.size() > 0) begin
            check("data_out", bus.data_out, q[0].data);
            check("syndrome", bus.syndrome_out, q[0].syn);
            check("err_corr", bus.err_corr, q[0].c);
            check("err_uncorr", bus.err_uncorr, q[0].u);
        end
        acc  = bus.in_valid && bus.in_ready;
        xfer = bus.out_valid && bus.out_ready;
        @(posedge clk);
        if (CNT_EN) begin
            if (bus.cnt_clr) begin
                mc = 0;
                mu = 0;
            end else if (xfer && q.size() > 0) begin
                if (q[0].c && mc < CMAX) mc++;
                if (q[0].u && mu < CMAX) mu++;
            end
        end
        if (xfer && q.size() > 0) void'(q.pop_front());
        if (acc && src.size() > 0) begin
            item_t it;
            it = src.pop_front();
            it.acc = cyc;
            q.push_back(it);
        end
        cyc++;
        @(negedge clk);
        check("corr_cnt", bus.corr_cnt, mc);
        check("uncorr_cnt", bus.uncorr_cnt, mu);
    endtask

    task automatic drive(input bit v, input bit r, input bit clr);
        bus.in_valid  = v && src.size() > 0;
        bus.code_in   = src.size() > 0 ? src[0].code : 16'h0;
        bus.out_ready = r;
        bus.cnt_clr   = clr;
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.code_in   = '0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_corr", bus.err_corr, 0);
        check("rst_uncorr", bus.err_uncorr, 0);
        check("rst_syn", bus.syndrome_out, 0);
        check("rst_corr_cnt", bus.corr_cnt, 0);
        check("rst_uncorr_cnt", bus.uncorr_cnt, 0);
        rst = 1'b0;

        src.push_back(fixed(16'hB42D, 11'h5A3, 4'd0, 1'b0, 1'b0));
        src.push_back(fixed(16'hB46D, 11'h5A3, 4'd6, 1'b1, 1'b0));
        src.push_back(fixed(16'hB42C, 11'h5A3, 4'd0, 1'b1, 1'b0));
        src.push_back(fixed(16'hB66D, 11'h5B7, 4'd15, 1'b0, 1'b1));
        drive(1, 1, 0);
        check("lat_edge1", bus.out_valid, 0);
        drive(1, 1, 0);
        check("lat_edge2", bus.out_valid, 1);
        for (int i = 0; i < 6; i++) drive(1, 1, 0);

        for (int i = 0; i < 4; i++)
            src.push_back(mk(11'($urandom), int'($urandom_range(2))));
        for (int i = 0; i < 3; i++) drive(1, 0, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 0);

        for (int i = 0; i < 400; i++) begin
            if (src.size() < 2)
                src.push_back(mk(11'($urandom), int'($urandom_range(2))));
            drive($urandom_range(3) != 0, $urandom_range(9) < 7,
                  $urandom_range(19) == 0);
        end
        src.delete();
        for (int i = 0; i < 6; i++) drive(0, 1, 0);
        check("drain", q.size(), 0);

        drive(0, 1, 1);
        for (int i = 0; i < 5; i++) src.push_back(mk(11'($urandom), 1));
        for (int i = 0; i < 10; i++) drive(1, 1, 0);
        check("sat_corr", bus.corr_cnt, CNT_EN ? CMAX : 0);

        src.push_back(mk(11'($urandom), 1));
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 1);
        check("clr_prio", bus.corr_cnt, 0);

        for (int i = 0; i < 4; i++) src.push_back(mk(11'($urandom), 1));
        for (int i = 0; i < 3; i++) drive(1, 1, 0);
        bus.in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_corr_cnt", bus.corr_cnt, 0);
        check("mid_rst_uncorr_cnt", bus.uncorr_cnt, 0);
        check("mid_rst_data", bus.data_out, 0);
        check("mid_rst_flags", {bus.err_corr, bus.err_uncorr}, 0);
        check("mid_rst_syn", bus.syndrome_out, 0);
        q.delete();
        src.delete();
        mc = 0;
        mu = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0);

        for (int i = 0; i < 6; i++)
            src.push_back(mk(11'($urandom), int'($urandom_range(2))));
        for (int i = 0; i < 12; i++) drive(1, $urandom_range(1) == 1, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0);
        check("final_drain", q.size() + src.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
